// File: rtl/memory_param.sv
// Parametrised single-port synchronous RAM with a built-in clear sequencer.
// Ports: CLK, RST (sync, active-high), EN/WE/ADDRESS/DI access, CLEAR request,
//        DO (registered read data), DO_VALID (read strobe), BUSY (clearing).
module memory_param #(
    parameter int                    DATA_WIDTH = 8,
    parameter int                    ADDR_WIDTH = 11,
    parameter int                    RDW_MODE   = 0,
    parameter logic [DATA_WIDTH-1:0] INIT_VALUE = '0
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic                  EN,
    input  logic [ADDR_WIDTH-1:0] ADDRESS,
    input  logic                  WE,
    input  logic [DATA_WIDTH-1:0] DI,
    input  logic                  CLEAR,
    output logic [DATA_WIDTH-1:0] DO,
    output logic                  DO_VALID,
    output logic                  BUSY
);

    localparam int DEPTH = 2 ** ADDR_WIDTH;
    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = '1;
    localparam logic [ADDR_WIDTH-1:0] ADDR_ONE  = 1;

    typedef enum logic {
        S_CLR,
        S_IDLE
    } state_t;

    state_t                  state_q;
    state_t                  state_d;
    logic [ADDR_WIDTH-1:0]   clr_addr_q;
    logic [ADDR_WIDTH-1:0]   clr_addr_d;

    logic                    mem_we;
    logic [ADDR_WIDTH-1:0]   mem_addr;
    logic [DATA_WIDTH-1:0]   mem_wdata;
    logic                    rd_en;
    logic                    rd_fwd;

    logic [DATA_WIDTH-1:0]   mem [DEPTH];

    // Next-state and datapath control. RST suppresses every memory
    // access so a reset never disturbs stored contents.
    always_comb begin
        state_d    = state_q;
        clr_addr_d = clr_addr_q;
        mem_we     = 1'b0;
        mem_addr   = ADDRESS;
        mem_wdata  = DI;
        rd_en      = 1'b0;
        rd_fwd     = 1'b0;
        if (!RST) begin
            unique case (state_q)
                S_CLR: begin
                    mem_we     = 1'b1;
                    mem_addr   = clr_addr_q;
                    mem_wdata  = INIT_VALUE;
                    clr_addr_d = clr_addr_q + ADDR_ONE;
                    // Terminal compare: leave before the counter wraps.
                    if (clr_addr_q == LAST_ADDR) begin
                        state_d = S_IDLE;
                    end
                end
                S_IDLE: begin
                    if (CLEAR) begin
                        state_d    = S_CLR;
                        clr_addr_d = '0;
                    end else if (EN) begin
                        if (WE) begin
                            mem_we = 1'b1;
                            rd_en  = (RDW_MODE != 2);
                            rd_fwd = (RDW_MODE == 1);
                        end else begin
                            rd_en = 1'b1;
                        end
                    end
                end
                default: begin
                    state_d = S_CLR;
                end
            endcase
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q    <= S_CLR;
            clr_addr_q <= '0;
        end else begin
            state_q    <= state_d;
            clr_addr_q <= clr_addr_d;
        end
    end

    // Array has no reset so it maps onto block RAM.
    always_ff @(posedge CLK) begin
        if (mem_we) begin
            mem[mem_addr] <= mem_wdata;
        end
    end

    // Reading the array in its own process yields the pre-write word,
    // which is the read-first result; write-first forwards DI instead.
    always_ff @(posedge CLK) begin
        if (RST) begin
            DO <= '0;
        end else if (rd_en) begin
            DO <= rd_fwd ? DI : mem[ADDRESS];
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            DO_VALID <= 1'b0;
        end else begin
            DO_VALID <= rd_en;
        end
    end

    assign BUSY = (state_q == S_CLR);

endmodule

// File: doc/memory_param.md
Name: memory_param

Overview:
Parametrised single-port synchronous RAM. It generalises the fixed 2048 x 8 memory to arbitrary width and depth. It adds a selectable read-during-write mode, a read-valid strobe, and a built-in clear sequencer that fills the array with INIT_VALUE after reset or on request. It sits wherever the design needs local buffer storage behind a simple EN/WE/ADDRESS interface.

Parameters:
DATA_WIDTH, 8, width of DI/DO in bits
ADDR_WIDTH, 11, address width; DEPTH = 2**ADDR_WIDTH words
RDW_MODE, 0, read-during-write: 0 = read-first (DO gets old word), 1 = write-first (DO gets DI), 2 = no-change (DO holds)
INIT_VALUE, 0, DATA_WIDTH-bit word written to every location by the clear sequencer

Ports:
CLK  in  1  clock, all logic on rising edge
RST  in  1  reset; synchronous, active-high
EN  in  1  access enable, 1 = enable
ADDRESS  in  ADDR_WIDTH  word address 0..DEPTH-1
WE  in  1  write enable, 1 = write (qualified by EN)
DI  in  DATA_WIDTH  write data
CLEAR  in  1  request to re-run clear sequence, sampled in IDLE only
DO  out  DATA_WIDTH  read data, registered
DO_VALID  out  1  1-cycle strobe: DO updated by a read this cycle
BUSY  out  1  1 while clear sequencer runs; accesses ignored

Behaviour:
- Interface decision: one clock, CLK. Reset is synchronous and active-high, port RST.
- Reset: RST=1 at a rising edge gives DO=0, DO_VALID=0, BUSY=1, state=CLR, clear address=0. Memory contents are not touched by RST itself.
- FSM states are CLR and IDLE.
- CLR state:
  - Each cycle writes INIT_VALUE to mem[clr_addr], then clr_addr += 1.
  - At clr_addr = DEPTH-1, that write completes and the next state is IDLE.
  - BUSY is 1 for exactly DEPTH cycles after RST is released (or after CLEAR is accepted), then falls to 0.
- While in CLR:
  - EN, WE, DI, ADDRESS and CLEAR are ignored.
  - DO holds its value (0 after reset).
  - DO_VALID = 0.
- IDLE with CLEAR=1: the request is accepted and the FSM enters CLR with clr_addr=0. BUSY=1 from the next cycle. Any EN access in the same cycle is dropped.
- IDLE, EN=1, WE=0: DO <= mem[ADDRESS] at this edge; DO_VALID=1 for the following cycle. Read latency is 1 clock.
- IDLE, EN=1, WE=1: mem[ADDRESS] <= DI at this edge. DO and DO_VALID follow RDW_MODE:
  - 0: DO <= old mem[ADDRESS], DO_VALID=1.
  - 1: DO <= DI, DO_VALID=1.
  - 2: DO unchanged, DO_VALID=0.
- IDLE, EN=0: no access; DO holds; DO_VALID=0. WE is ignored when EN=0.
- Back-to-back accesses: one access per cycle, no bubbles. A read of an address written the previous cycle returns the new data.
- Address width: ADDRESS is exactly ADDR_WIDTH bits, so there is no out-of-range case. The clear counter is ADDR_WIDTH+1 bits or uses a terminal compare, and must not wrap back to 0 before exiting CLR.
- RST during CLR: restart the clear at address 0 with a full DEPTH-cycle BUSY.
- RST during IDLE: any in-flight access is dropped, then the clear runs.
- RST has priority over CLEAR and EN.
- Storage must infer block RAM: single write port, registered read, no reset on the array.

Test Plan:
- Defaults, RST=1 for 2 cycles then 0: DO=0 and BUSY=1 for 2048 cycles, then BUSY=0. Reads of addr 0, 1, 7, 0x787, 0x7FF all return 0x00 with DO_VALID=1 one cycle after EN.
- Sequential fill: write (addr, 0xFF - addr[7:0]) to addr 0..2047, then read back. Requirements: addr 0 -> 0xFF, addr 1 -> 0xFE, addr 7 -> 0xF8, addr 0x787 -> 0x78, addr 0x7FF -> 0x00. Each result has 1-cycle latency and a 1-cycle DO_VALID.
- Read-during-write: mem[5]=0x3C, then write 0xA5 to addr 5 with EN=WE=1. Required DO per mode:
  - RDW_MODE=0: DO=0x3C, DO_VALID=1.
  - RDW_MODE=1: DO=0xA5, DO_VALID=1.
  - RDW_MODE=2: DO holds, DO_VALID=0.
  - In all modes, a read of addr 5 next cycle returns 0xA5.
- CLEAR with INIT_VALUE=0x5A after a fill: BUSY=1 for 2048 cycles starting the cycle after CLEAR. A write to addr 3 issued while BUSY is ignored. Afterwards, reads of addr 0, 3 and 2047 return 0x5A.
- RST asserted at clear cycle 1000: BUSY stays 1 and restarts, falling exactly 2048 cycles after RST deasserts.
- Parameter sweep, DATA_WIDTH=16 and ADDR_WIDTH=4: BUSY lasts 16 cycles. Write 0xBEEF to addr 15 and 0x1234 to addr 0; reads return 0xBEEF and 0x1234, and addr 8 returns INIT_VALUE.
